// File: rtl/btn_tone_pkg.sv
// Shared state encoding and width helper for the button tone player.
package btn_tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Width needed to index n items; never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_tone_player_debouncer.sv
// One-bit two-flop synchroniser followed by a consecutive-cycle debounce counter.
module debouncer
  import btn_tone_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = clog2w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          meta_r;
  logic          sync_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;

  // Synchronise, then flip the level only after an unbroken run of mismatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r  <= 1'b0;
      sync_r  <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      if (sync_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync_r;
          cnt_r   <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign dout = level_r;

endmodule

// File: rtl/btn_tone_player.sv
// Debounced buttons pick a channel; its half-period drives a square wave on
// sound for at least HOLD_CYCLES clocks, extended while the button is held.
module btn_tone_player
  import btn_tone_pkg::*;
#(
  parameter int N_BTNS          = 4,
  parameter int DIV_W           = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 5000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_BTNS-1:0]         btns,
  input  logic [N_BTNS*DIV_W-1:0]   half_periods,
  input  logic                      enable,
  output logic [clog2w(N_BTNS)-1:0] num,
  output logic                      pressed,
  output logic [N_BTNS-1:0]         leds,
  output logic                      sound
);

  localparam int NUM_W = clog2w(N_BTNS);
  localparam int HW    = clog2w(HOLD_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_PLAY = PLAY;
  localparam logic [1:0] ST_HOLD = HOLD;

  localparam logic [HW-1:0]     HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]     HOLD_ONE = HW'(1);
  localparam logic [DIV_W-1:0]  HP_ONE   = DIV_W'(1);
  localparam logic [N_BTNS-1:0] LED_ONE  = N_BTNS'(1);

  logic [N_BTNS-1:0] db_s;
  logic [DIV_W-1:0]  hp_arr_s [N_BTNS];
  logic              any_s;
  logic [NUM_W-1:0]  low_idx_s;
  logic [1:0]        state_nxt_s;
  logic              start_s;
  logic              cur_s;
  logic              hold_done_s;
  logic [NUM_W-1:0]  num_nxt_s;
  logic              pressed_nxt_s;
  logic [DIV_W-1:0]  hp_sel_s;

  logic [1:0]        state_r;
  logic [NUM_W-1:0]  num_r;
  logic [DIV_W-1:0]  hp_r;
  logic [DIV_W-1:0]  tone_cnt_r;
  logic [HW-1:0]     hold_cnt_r;
  logic              sound_r;
  logic              pressed_r;
  logic [N_BTNS-1:0] leds_r;

  for (genvar g = 0; g < N_BTNS; g++) begin : g_db
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .din (btns[g]),
      .dout(db_s[g])
    );
  end

  // Priority encoder (lowest index wins) and per-channel half-period unpacking.
  always_comb begin
    any_s     = |db_s;
    low_idx_s = '0;
    for (int i = N_BTNS - 1; i >= 0; i--) begin
      low_idx_s = db_s[i] ? NUM_W'(i) : low_idx_s;
    end
    for (int i = 0; i < N_BTNS; i++) begin
      hp_arr_s[i] = half_periods[i*DIV_W +: DIV_W];
    end
  end

  assign cur_s       = db_s[num_r];
  assign hold_done_s = (hold_cnt_r >= HOLD_MAX);
  assign hp_sel_s    = hp_arr_s[low_idx_s];

  // Next-state logic; PLAY and HOLD differ only in which way the button moved.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (enable && any_s) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PLAY, ST_HOLD: begin
        if (cur_s) begin
          state_nxt_s = ST_PLAY;
        end else if (hold_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign start_s       = (state_r == ST_IDLE) && (state_nxt_s == ST_PLAY);
  assign num_nxt_s     = start_s ? low_idx_s : num_r;
  assign pressed_nxt_s = (state_nxt_s != ST_IDLE);

  // State, tone and hold counters, and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      num_r      <= '0;
      hp_r       <= '0;
      tone_cnt_r <= '0;
      hold_cnt_r <= '0;
      sound_r    <= 1'b0;
      pressed_r  <= 1'b0;
      leds_r     <= '0;
    end else begin
      state_r   <= state_nxt_s;
      num_r     <= num_nxt_s;
      pressed_r <= pressed_nxt_s;
      leds_r    <= pressed_nxt_s ? (LED_ONE << num_nxt_s) : '0;
      if (start_s) begin
        hp_r       <= (hp_sel_s == '0) ? HP_ONE : hp_sel_s;
        tone_cnt_r <= '0;
        hold_cnt_r <= '0;
        sound_r    <= 1'b0;
      end else if (!pressed_nxt_s) begin
        tone_cnt_r <= '0;
        hold_cnt_r <= '0;
        sound_r    <= 1'b0;
      end else begin
        if (tone_cnt_r == (hp_r - HP_ONE)) begin
          tone_cnt_r <= '0;
          sound_r    <= ~sound_r;
        end else begin
          tone_cnt_r <= tone_cnt_r + HP_ONE;
        end
        if (!hold_done_s) begin
          hold_cnt_r <= hold_cnt_r + HOLD_ONE;
        end else begin
          hold_cnt_r <= hold_cnt_r;
        end
      end
    end
  end

  assign num     = num_r;
  assign pressed = pressed_r;
  assign leds    = leds_r;
  assign sound   = sound_r;

endmodule
